// File: rtl/note_scheduler_if.sv
// Key-event bus between the PS/2 side, the octave decoder and the tone generator.
// The master drives bytes and controls; the slave returns the sounding-note state.
interface note_scheduler_if;
  logic [7:0] scancode;
  logic       scancode_valid;
  logic [1:0] mode;
  logic       all_off;
  logic [3:0] note;
  logic [1:0] octave;
  logic       gate;
  logic       note_change;

  modport master (
    output scancode, scancode_valid, mode, all_off,
    input  note, octave, gate, note_change
  );

  modport slave (
    input  scancode, scancode_valid, mode, all_off,
    output note, octave, gate, note_change
  );
endinterface

// File: rtl/note_scheduler.sv
// Make/break parser plus a last-note-priority stack of held keys.
// Outputs are registered and follow an event byte by one cycle.
module note_scheduler #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  note_scheduler_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] note;
  } key_t;

  state_t                state;
  logic [DEPTH-1:0][3:0] stk, stk_n;
  logic [CW-1:0]         cnt, cnt_n;

  key_t       key;
  logic       take, press, rel, push, held, gate_n;
  int         held_idx;
  logic [3:0] note_n;
  logic [1:0] oct_n;

  function automatic key_t key_map(input logic [7:0] c);
    key_t k;
    k.hit = 1'b1;
    case (c)
      8'h1C:   k.note = 4'd0;
      8'h1D:   k.note = 4'd1;
      8'h1B:   k.note = 4'd2;
      8'h24:   k.note = 4'd3;
      8'h23:   k.note = 4'd4;
      8'h2B:   k.note = 4'd5;
      8'h2C:   k.note = 4'd6;
      8'h34:   k.note = 4'd7;
      8'h35:   k.note = 4'd8;
      8'h33:   k.note = 4'd9;
      8'h3C:   k.note = 4'd10;
      8'h3B:   k.note = 4'd11;
      8'h42:   k.note = 4'd12;
      default: begin k.hit = 1'b0; k.note = 4'd0; end
    endcase
    return k;
  endfunction

  always_comb begin
    key   = key_map(bus.scancode);
    // all_off swallows a coincident byte entirely
    take  = bus.scancode_valid && !bus.all_off;
    press = take && (state == IDLE) && key.hit;
    rel   = take && (state == BRK)  && key.hit;

    held     = 1'b0;
    held_idx = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!held && (i < int'(cnt)) && (stk[i] == key.note)) begin
        held     = 1'b1;
        held_idx = i;
      end
    end

    stk_n = stk;
    cnt_n = cnt;
    push  = 1'b0;
    if (bus.all_off) begin
      cnt_n = '0;
    end else if (press && !held) begin
      push = 1'b1;
      if (int'(cnt) == DEPTH) begin
        // full: oldest entry falls off the bottom
        for (int i = 0; i < DEPTH - 1; i++) stk_n[i] = stk[i+1];
        stk_n[DEPTH-1] = key.note;
      end else begin
        for (int i = 0; i < DEPTH; i++)
          if (i == int'(cnt)) stk_n[i] = key.note;
        cnt_n = cnt + 1'b1;
      end
    end else if (rel && held) begin
      for (int i = 0; i < DEPTH - 1; i++)
        if (i >= held_idx) stk_n[i] = stk[i+1];
      cnt_n = cnt - 1'b1;
    end

    // empty stack keeps the last sounding note
    note_n = bus.note;
    for (int i = 0; i < DEPTH; i++)
      if (i + 1 == int'(cnt_n)) note_n = stk_n[i];

    oct_n  = push ? ((bus.mode == 2'd0) ? 2'd1 : bus.mode) : bus.octave;
    gate_n = (cnt_n != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      stk             <= '0;
      cnt             <= '0;
      bus.note        <= 4'd0;
      bus.octave      <= 2'd1;
      bus.gate        <= 1'b0;
      bus.note_change <= 1'b0;
    end else begin
      if (bus.all_off) begin
        state <= IDLE;
      end else if (bus.scancode_valid) begin
        case (state)
          IDLE:    state <= (bus.scancode == 8'hF0) ? BRK :
                            (bus.scancode == 8'hE0) ? EXT : IDLE;
          BRK:     state <= IDLE;
          EXT:     state <= (bus.scancode == 8'hF0) ? EXT_BRK : IDLE;
          EXT_BRK: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
      stk             <= stk_n;
      cnt             <= cnt_n;
      bus.note        <= note_n;
      bus.octave      <= oct_n;
      bus.gate        <= gate_n;
      bus.note_change <= (note_n != bus.note) || (oct_n != bus.octave) ||
                         (gate_n != bus.gate);
    end
  end
endmodule

// File: doc/note_scheduler.md
# note_scheduler

Key-event scheduler between the PS/2 scancode receiver and the tone generator. Parses make/break sequences, keeps up to four held note keys in press order, and drives the tone generator with the most recently pressed held note (last-note priority), a gate, and an octave. The octave comes from the existing octave-mode decoder's 2-bit mode.

## Interface
- `DEPTH`, 4: held-note stack entries; legal range 2–8.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `scancode`  in  8  byte from the PS/2 receiver.
- `scancode_valid`  in  1  one-cycle strobe; `scancode` is valid while this is high.
- `mode`  in  2  octave selection from the octave-mode decoder, values 1–3.
- `all_off`  in  1  synchronous flush of all held notes.
- `note`  out  4  semitone index of the sounding note, 0–12.
- `octave`  out  2  octave the tone generator plays `note` in, values 1–3.
- `gate`  out  1  high while at least one mapped key is held.
- `note_change`  out  1  one-cycle pulse when `note`, `octave` or `gate` changes.

## Operation
- **Key map (make codes to notes):**
  - 1C→0, 1D→1, 1B→2, 24→3, 23→4, 2B→5, 2C→6, 34→7, 35→8, 33→9, 3C→10, 3B→11, 42→12.
  - All other codes are unmapped.
- **Parser FSM states:** IDLE, BRK, EXT, EXT_BRK. It advances only on cycles with `scancode_valid` high.
  - IDLE: F0→BRK; E0→EXT; mapped code → press event, stay IDLE; anything else → stay IDLE.
  - BRK: mapped code → release event; any code → IDLE.
  - EXT: F0→EXT_BRK; any other code → IDLE, ignored.
  - EXT_BRK: any code → IDLE, ignored. Extended keys never affect notes.
- **Stack:** entries 0..count-1, with entry count-1 on top. `count` ranges 0..DEPTH.
- **Press of a note already held** (typematic repeat): no change; `note_change` stays low.
- **Press of a new note, stack not full:** push on top.
- **Press of a new note, stack full:** discard entry 0, shift the others down, push the new note on top.
- **Release of a held note:** remove its entry and compact the entries above it down by one. If the top entry is removed, the next entry becomes the sounding note.
- **Release of a note not held:** ignored.
- **`note`:** top entry when count>0. When the stack becomes empty, holds the last sounding value.
- **`gate`:** (count != 0).
- **`octave`:**
  - Loaded from `mode` only on a press event that pushes a note; `mode`=0 loads 1.
  - Held through releases and typematic repeats.
  - Changes to `mode` while a note sounds take effect on the next push.
- **`all_off`:**
  - Sets count=0 and the parser to IDLE; `note` and `octave` hold.
  - If asserted in the same cycle as `scancode_valid`, `all_off` wins and the byte is discarded.

## Timing
- **Reset values (asynchronous):** parser IDLE, count=0, all entries 0, `note`=0, `octave`=1, `gate`=0, `note_change`=0.
- **Latency:** all outputs are registered. An event byte sampled at edge N is reflected in `note`, `octave`, `gate` and `note_change` right after edge N, i.e. one cycle of latency from strobe to output.
- **`note_change`:**
  - High for exactly the one cycle following an edge where any of `note`, `octave`, `gate` changed value; low otherwise.
  - Does not pulse on reset.
- **Strobe spacing:** back-to-back strobes on consecutive cycles must be accepted with no byte lost.
- **Reset mid-sequence:** reset asserted between F0 and its following code clears the BRK state, so that following code is treated as a make code.

## Test plan
- **Single press/release:** strobe 1C, then F0, 1C with `mode`=2 → after the first strobe, `note`=0, `octave`=2, `gate`=1, `note_change` pulses once. After the final 1C, `gate`=0, `note` stays 0, `note_change` pulses once.
- **Last-note priority:** press 1C, 23, 3B; release 3B (F0 3B) → `note` goes 0, 4, 11, then 4. `gate` stays 1 throughout.
- **Overflow, DEPTH=4:** press 1C, 1D, 1B, 24, 23, then release 23, 24, 1B, 1D → `note` goes 4, 3, 2, 1, then `gate`=0. Note 0 was evicted on the fifth press and never reappears.
- **Repeat and extended codes:**
  - Press 1C, then 1C, 1C → exactly one `note_change` pulse.
  - Then E0 F0 1C, then E0 1C → `gate` stays 1, `note` stays 0.
- **Octave and mode:** press 1C with `mode`=1, set `mode`=3, press 23 → `octave` goes 1 then 3. Release 23 → `note`=0, `octave` stays 3. `mode`=0 on a later push loads `octave`=1.
- **all_off and reset:**
  - Hold 3 notes, assert `all_off` in the same cycle as a strobe of 42 → `gate`=0 next cycle, 42 not pushed.
  - Strobe F0, assert `reset`, strobe 1C → `gate`=1, `note`=0.
